// File: rtl/wave_sequencer.sv
// Phase-accumulator sequencer for a note voice: gated IDLE/RUN/RELEASE phase ramp,
// three-stage fetch pipeline against external registered waveform blocks, and a config handshake.
module wave_sequencer #(
    parameter logic [15:0] DEFAULT_INCR = 16'd256,
    parameter logic [1:0]  DEFAULT_SEL  = 2'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sample_tick,
    input  logic        i_gate,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [15:0] i_cfg_incr,
    input  logic [1:0]  i_cfg_sel,
    output logic [15:0] o_addr,
    output logic [1:0]  o_sel,
    input  logic [15:0] i_wave_data,
    output logic [15:0] o_sample,
    output logic        o_sample_valid,
    output logic        o_overrun
);

    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] incr_q, incr_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  pend_sel_q, pend_sel_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  vld_pipe_q, vld_pipe_d;
    logic [1:0]  zero_pipe_q, zero_pipe_d;
    logic [15:0] sample_q, sample_d;
    logic        sample_vld_q, sample_vld_d;
    logic        overrun_q, overrun_d;

    logic        busy;
    logic        tick_acc;
    logic        cfg_acc;
    logic        tick_zero;
    logic [16:0] sum;

    assign busy     = |vld_pipe_q;
    assign tick_acc = i_sample_tick & ~busy;
    assign cfg_acc  = i_cfg_valid & o_cfg_ready;
    assign sum      = {1'b0, phase_q} + {1'b0, incr_q};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        tick_zero = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d   = 16'd0;
                tick_zero = 1'b1;
                if (i_gate) state_d = RUN;
            end
            RUN: begin
                if (tick_acc) phase_d = sum[15:0];
                if (!i_gate)  state_d = RELEASE;
            end
            RELEASE: begin
                // The tick that ends the release tail is itself muted.
                if (tick_acc && (sum[16] || incr_q == 16'd0)) begin
                    phase_d   = 16'd0;
                    state_d   = IDLE;
                    tick_zero = 1'b1;
                end else begin
                    if (tick_acc) phase_d = sum[15:0];
                    if (i_gate)   state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = 16'd0;
            end
        endcase
    end

    always_comb begin
        incr_d       = cfg_acc ? i_cfg_incr : incr_q;
        sel_d        = sel_q;
        pend_sel_d   = pend_sel_q;
        pend_vld_d   = pend_vld_q;
        // A select arriving with a tick must not steer that tick's fetch: park it until capture.
        if (cfg_acc && tick_acc) begin
            pend_sel_d = i_cfg_sel;
            pend_vld_d = 1'b1;
        end else if (cfg_acc) begin
            sel_d = i_cfg_sel;
        end else if (pend_vld_q && vld_pipe_q[1]) begin
            sel_d      = pend_sel_q;
            pend_vld_d = 1'b0;
        end
        vld_pipe_d   = {vld_pipe_q[0], tick_acc};
        zero_pipe_d  = {zero_pipe_q[0], tick_acc & tick_zero};
        sample_d     = sample_q;
        if (vld_pipe_q[1]) sample_d = zero_pipe_q[1] ? 16'd0 : i_wave_data;
        sample_vld_d = vld_pipe_q[1];
        overrun_d    = overrun_q | (i_sample_tick & busy);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 16'd0;
            incr_q       <= DEFAULT_INCR;
            sel_q        <= DEFAULT_SEL;
            pend_sel_q   <= DEFAULT_SEL;
            pend_vld_q   <= 1'b0;
            vld_pipe_q   <= 2'b00;
            zero_pipe_q  <= 2'b00;
            sample_q     <= 16'd0;
            sample_vld_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            incr_q       <= incr_d;
            sel_q        <= sel_d;
            pend_sel_q   <= pend_sel_d;
            pend_vld_q   <= pend_vld_d;
            vld_pipe_q   <= vld_pipe_d;
            zero_pipe_q  <= zero_pipe_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            overrun_q    <= overrun_d;
        end
    end

    // Ready drops the instant reset asserts, not at the next edge.
    assign o_cfg_ready    = i_rst_n & ~busy;
    assign o_addr         = phase_q;
    assign o_sel          = sel_q;
    assign o_sample       = sample_q;
    assign o_sample_valid = sample_vld_q;
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: per-cycle vector table plus hand sequences for
// overrun, config back-pressure and reset during a fetch.
module tb_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, gate = 1'b0, cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_incr = 16'd0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [15:0] addr, sample;
    logic [1:0]  sel;
    logic [15:0] wave;
    logic        sample_valid, overrun;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wave_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_gate(gate),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_incr(cfg_incr),
        .i_cfg_sel(cfg_sel), .o_addr(addr), .o_sel(sel), .i_wave_data(wave),
        .o_sample(sample), .o_sample_valid(sample_valid), .o_overrun(overrun)
    );

    // External waveform blocks behind the select mux: sel 0 square, sel 1 saw, else inverted saw.
    always_ff @(posedge clk) begin
        case (sel)
            2'd0:    wave <= addr[15] ? 16'h7FFF : 16'h8001;
            2'd1:    wave <= addr;
            default: wave <= ~addr;
        endcase
    end

    typedef struct {
        logic        t, g, cv;
        logic [15:0] ci;
        logic [1:0]  cs;
        logic [15:0] e_addr;
        logic [1:0]  e_sel;
        logic        e_vld;
        logic [15:0] e_smp;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic t, logic g, logic cv, logic [15:0] ci, logic [1:0] cs,
                                logic [15:0] ea, logic [1:0] es, logic ev, logic [15:0] esm,
                                logic er);
        vec_t v;
        v.t = t; v.g = g; v.cv = cv; v.ci = ci; v.cs = cs;
        v.e_addr = ea; v.e_sel = es; v.e_vld = ev; v.e_smp = esm; v.e_rdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic g, input logic cv,
                         input logic [15:0] ci, input logic [1:0] cs);
        tick = t; gate = g; cfg_valid = cv; cfg_incr = ci; cfg_sel = cs;
    endtask

    initial begin
        // tick gate cv incr sel | addr sel vld sample rdy  (outputs after the edge)
        vecs.push_back(mk(0,0,1,16'h4000,0, 16'h0000,0,0,16'h0000,1));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h0000,0,0,16'h0000,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h4000,0,0,16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,0,16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,1,16'h8001,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h8000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h8000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h8000,0,1,16'h7FFF,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'hC000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'hC000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'hC000,0,1,16'h7FFF,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h0000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h0000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h0000,0,1,16'h8001,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h4000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,1,16'h8001,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h8000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h8000,0,0,16'h8001,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h8000,0,1,16'h7FFF,1));
        // gate off at phase 0x8000: release tail, wrap to IDLE, muted samples
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'h8000,0,0,16'h7FFF,1));
        vecs.push_back(mk(1,0,0,16'h0000,0, 16'hC000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'hC000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'hC000,0,1,16'h7FFF,1));
        vecs.push_back(mk(1,0,0,16'h0000,0, 16'h0000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0000,0,0,16'h7FFF,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0000,0,1,16'h0000,1));
        vecs.push_back(mk(1,0,0,16'h0000,0, 16'h0000,0,0,16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0000,0,0,16'h0000,0));
        vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0000,0,1,16'h0000,1));
        // new config (saw, 0x1000) while idle, then note on
        vecs.push_back(mk(0,1,1,16'h1000,1, 16'h0000,1,0,16'h0000,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h1000,1,0,16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h1000,1,0,16'h0000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h1000,1,1,16'h1000,1));
        // tick and config on the same edge: old incr and select serve this tick
        vecs.push_back(mk(1,1,1,16'h2000,0, 16'h2000,1,0,16'h1000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h2000,1,0,16'h1000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h2000,0,1,16'h2000,1));
        vecs.push_back(mk(1,1,0,16'h0000,0, 16'h4000,0,0,16'h2000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,0,16'h2000,0));
        vecs.push_back(mk(0,1,0,16'h0000,0, 16'h4000,0,1,16'h8001,1));

        // reset state
        #1;
        chk("rst_addr", addr, 16'h0000);
        chk("rst_sel", sel, 2'd0);
        chk("rst_vld", sample_valid, 1'b0);
        chk("rst_sample", sample, 16'h0000);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_rdy", cfg_ready, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", cfg_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].t, vecs[i].g, vecs[i].cv, vecs[i].ci, vecs[i].cs);
            step();
            chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
            chk($sformatf("v%0d_sel", i), sel, vecs[i].e_sel);
            chk($sformatf("v%0d_vld", i), sample_valid, vecs[i].e_vld);
            chk($sformatf("v%0d_sample", i), sample, vecs[i].e_smp);
            chk($sformatf("v%0d_rdy", i), cfg_ready, vecs[i].e_rdy);
        end
        chk("table_ovr", overrun, 1'b0);

        // back-to-back ticks: second ignored, overrun sticks, phase advances once
        drive(1,1,0,0,0); step();
        chk("ovr_addr0", addr, 16'h6000);
        step();
        chk("ovr_addr1", addr, 16'h6000);
        chk("ovr_flag", overrun, 1'b1);
        drive(0,1,0,0,0); step();
        chk("ovr_vld", sample_valid, 1'b1);
        chk("ovr_sample", sample, 16'h8001);
        step();
        chk("ovr_vld_end", sample_valid, 1'b0);
        step();
        chk("ovr_no_2nd", sample_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);

        // config offered during a fetch waits for the capture edge
        drive(1,1,0,0,0); step();
        chk("cfgw_addr", addr, 16'h8000);
        drive(0,1,1,16'h1000,0);
        #1 chk("cfgw_rdy0", cfg_ready, 1'b0);
        step();
        chk("cfgw_rdy1", cfg_ready, 1'b0);
        step();
        chk("cfgw_rdy2", cfg_ready, 1'b1);
        chk("cfgw_vld", sample_valid, 1'b1);
        step();
        drive(1,1,0,0,0); step();
        chk("cfgw_incr", addr, 16'h9000);
        drive(0,1,0,0,0); step(); step(); step();

        // reset one cycle into a fetch: everything clears, no late valid
        drive(0,1,1,16'h3000,1); step();
        chk("rstm_sel", sel, 2'd1);
        drive(1,1,0,0,0); step();
        chk("rstm_addr", addr, 16'hC000);
        drive(0,1,0,0,0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_addr0", addr, 16'h0000);
        chk("rstm_sel0", sel, 2'd0);
        chk("rstm_sample0", sample, 16'h0000);
        chk("rstm_vld0", sample_valid, 1'b0);
        chk("rstm_ovr0", overrun, 1'b0);
        chk("rstm_rdy0", cfg_ready, 1'b0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rstm_novld%0d", i), sample_valid, 1'b0);
        end
        chk("rstm_rdy1", cfg_ready, 1'b1);
        drive(1,1,0,0,0); step();
        chk("rstm_default_incr", addr, 16'h0100);
        drive(0,1,0,0,0); step(); step();
        chk("rstm_vld_new", sample_valid, 1'b1);
        chk("rstm_sample_new", sample, 16'h8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
